shift_add_multiplier: RTL and testbench

Sequential multiply datapath that sits directly downstream of the multicycle ControlUnit. It consumes the unit's MULT_EN/LDA/LDQ-style strobes and the register-file operands. It produces a double-width product for the writeback path. It uses an A (accumulator), Q (multiplier) and M (multiplicand) register with one add/shift step per clock, and signals completion back to the control FSM.

---
 rtl/shift_add_multiplier.sv | 161 ++++++++++++++++
 tb/tb_shift_add_multiplier.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential add/shift multiplier: one partial-product step per clock, {A,Q} product after WIDTH+1 cycles.
// Define MULT_BOOTH_SIGNED_EN to build a radix-2 Booth signed multiplier instead of the unsigned one.
module shift_add_multiplier #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CLR,
    input  logic               MULT_EN,
    input  logic               LDA,
    input  logic               LDQ,
    input  logic [WIDTH-1:0]   OPA,
    input  logic [WIDTH-1:0]   OPB,
    output logic [2*WIDTH-1:0] PRODUCT,
    output logic               BUSY,
    output logic               DONE,
    output logic               ZERO,
    output logic [1:0]         DBG_STATE
);

    // Handshake: MULT_EN is a start strobe accepted only while the FSM is IDLE (BUSY low or the
    // DONE cycle); DONE pulses for one cycle with PRODUCT/ZERO valid and held until the next DONE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               zero_q, zero_d;
    logic [WIDTH:0]     sum;

`ifdef MULT_BOOTH_SIGNED_EN
    logic               qm1_q, qm1_d;

    // Sign-extended to WIDTH+1 bits so A-M with M = most-negative value cannot wrap.
    always_comb begin
        sum = {a_q[WIDTH-1], a_q};
        case ({q_q[0], qm1_q})
            2'b10:   sum = {a_q[WIDTH-1], a_q} - {m_q[WIDTH-1], m_q};
            2'b01:   sum = {a_q[WIDTH-1], a_q} + {m_q[WIDTH-1], m_q};
            default: sum = {a_q[WIDTH-1], a_q};
        endcase
    end
`else
    // sum[WIDTH] is the carry C; shifting it into A keeps the full unsigned product.
    always_comb begin
        sum = {1'b0, a_q};
        if (q_q[0]) begin
            sum = {1'b0, a_q} + {1'b0, m_q};
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        zero_d    = zero_q;
`ifdef MULT_BOOTH_SIGNED_EN
        qm1_d     = qm1_q;
`endif
        if (CLR) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (MULT_EN) begin
                        a_d     = '0;
                        m_d     = LDA ? OPA : m_q;
                        q_d     = LDQ ? OPB : q_q;
                        cnt_d   = CNT_W'(WIDTH);
                        busy_d  = 1'b1;
                        state_d = ST_ITER;
`ifdef MULT_BOOTH_SIGNED_EN
                        qm1_d   = 1'b0;
`endif
                    end
                end
                ST_ITER: begin
                    a_d   = sum[WIDTH:1];
                    q_d   = {sum[0], q_q[WIDTH-1:1]};
                    cnt_d = cnt_q - CNT_W'(1);
`ifdef MULT_BOOTH_SIGNED_EN
                    qm1_d = q_q[0];
`endif
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_FIN;
                    end
                end
                ST_FIN: begin
                    product_d = {a_q, q_q};
                    zero_d    = ({a_q, q_q} == '0);
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            zero_q    <= zero_d;
        end
    end

`ifdef MULT_BOOTH_SIGNED_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            qm1_q <= 1'b0;
        end else begin
            qm1_q <= qm1_d;
        end
    end
`endif

    assign PRODUCT   = product_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ZERO      = zero_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: vector table plus hand-written abort/overlap sequences.
module tb_shift_add_multiplier;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           clr;
    logic           mult_en;
    logic           lda;
    logic           ldq;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;
    logic           zero;
    logic [1:0]     dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2*W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs[8];

    shift_add_multiplier #(.WIDTH(W), .CNT_W(5)) dut (
        .CLK       (clk),
        .RST       (rst),
        .CLR       (clr),
        .MULT_EN   (mult_en),
        .LDA       (lda),
        .LDQ       (ldq),
        .OPA       (opa),
        .OPB       (opb),
        .PRODUCT   (product),
        .BUSY      (busy),
        .DONE      (done),
        .ZERO      (zero),
        .DBG_STATE (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle (or after the cycle budget).
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic la,
                            input logic lq, input logic [2*W-1:0] exp_p, input int repulse_at,
                            input string name);
        int edges;
        int busy_cnt;
        logic [2*W-1:0] e;
        exp_q.push_back(exp_p);
        opa = a; opb = b; lda = la; ldq = lq; mult_en = 1'b1;
        @(negedge clk);
        mult_en = 1'b0; lda = 1'b0; ldq = 1'b0;
        edges = 0;
        busy_cnt = 0;
        while (!done && edges < 60) begin
            if (busy) busy_cnt++;
            if (edges == repulse_at) begin
                mult_en = 1'b1; opa = 1; opb = 1; lda = 1'b1; ldq = 1'b1;
            end
            @(negedge clk);
            mult_en = 1'b0; lda = 1'b0; ldq = 1'b0;
            edges++;
        end
        e = exp_q.pop_front();
        check({name, " latency"}, 64'(edges), 64'(W + 1));
        check({name, " busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
        check({name, " busy_at_done"}, 64'(busy), 64'(0));
        check({name, " product"}, 64'(product), 64'(e));
        check({name, " zero"}, 64'(zero), 64'(e == '0));
    endtask

    task automatic count_done(input int cycles, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check(name, 64'(seen), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MULT_BOOTH_SIGNED_EN
        vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'h0000_0001};
        vecs[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
        vecs[3] = '{16'h1234, 16'h5678, 32'h0626_0060};
        vecs[4] = '{16'h8000, 16'h0002, 32'hFFFF_0000};
        vecs[5] = '{16'hFFFF, 16'h0001, 32'hFFFF_FFFF};
        vecs[6] = '{16'h8000, 16'h8000, 32'h4000_0000};
        vecs[7] = '{16'h00FF, 16'h0100, 32'h0000_FF00};
`else
        vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
        vecs[3] = '{16'h1234, 16'h5678, 32'h0626_0060};
        vecs[4] = '{16'h8000, 16'h0002, 32'h0001_0000};
        vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
        vecs[6] = '{16'h8000, 16'h8000, 32'h4000_0000};
        vecs[7] = '{16'h00FF, 16'h0100, 32'h0000_FF00};
`endif
        rst = 1'b1; clr = 1'b0; mult_en = 1'b0; lda = 1'b0; ldq = 1'b0; opa = '0; opb = '0;
        repeat (2) @(negedge clk);
        check("reset product", 64'(product), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset zero", 64'(zero), 64'(0));
        check("reset state", 64'(dbg_state), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_mult(vecs[i].a, vecs[i].b, 1'b1, 1'b1, vecs[i].p, -1, $sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d done_pulse", i), 64'(done), 64'(0));
        end

        // Operand reuse: M kept when LDA=0, Q keeps low product half when LDQ=0.
        run_mult(16'd3, 16'd5, 1'b1, 1'b1, 32'd15, -1, "load_both");
        @(negedge clk);
        run_mult(16'd99, 16'd4, 1'b0, 1'b1, 32'd12, -1, "keep_m");
        @(negedge clk);
        run_mult(16'd2, 16'd77, 1'b1, 1'b0, 32'd24, -1, "keep_q");
        @(negedge clk);

        // Start strobe while busy is ignored.
        run_mult(16'd7, 16'd9, 1'b1, 1'b1, 32'd63, 5, "repulse");
        @(negedge clk);
        check("repulse done_pulse", 64'(done), 64'(0));
        count_done(25, "repulse no_second_done");
        check("repulse product_held", 64'(product), 64'(63));

        // Back-to-back: second start issued in the DONE cycle.
        run_mult(16'd3, 16'd5, 1'b1, 1'b1, 32'd15, -1, "b2b_first");
        run_mult(16'd4, 16'd4, 1'b1, 1'b1, 32'd16, -1, "b2b_second");
        @(negedge clk);

        // Asynchronous reset mid-operation.
        opa = 16'd7; opb = 16'd9; lda = 1'b1; ldq = 1'b1; mult_en = 1'b1;
        @(negedge clk);
        mult_en = 1'b0; lda = 1'b0; ldq = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid product", 64'(product), 64'(0));
        check("rst_mid busy", 64'(busy), 64'(0));
        check("rst_mid done", 64'(done), 64'(0));
        check("rst_mid state", 64'(dbg_state), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        count_done(25, "rst_mid no_done");

        // Synchronous clear during ITER keeps the previous result.
        run_mult(16'd3, 16'd3, 1'b1, 1'b1, 32'd9, -1, "pre_clr");
        @(negedge clk);
        opa = 16'd2; opb = 16'd2; lda = 1'b1; ldq = 1'b1; mult_en = 1'b1;
        @(negedge clk);
        mult_en = 1'b0; lda = 1'b0; ldq = 1'b0;
        repeat (4) @(negedge clk);
        check("clr busy_before", 64'(busy), 64'(1));
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr busy", 64'(busy), 64'(0));
        check("clr state", 64'(dbg_state), 64'(0));
        check("clr product_held", 64'(product), 64'(9));
        check("clr zero_held", 64'(zero), 64'(0));
        count_done(25, "clr no_done");

        // CLR wins over MULT_EN in the same cycle.
        clr = 1'b1; mult_en = 1'b1; opa = 16'd5; opb = 16'd5; lda = 1'b1; ldq = 1'b1;
        @(negedge clk);
        clr = 1'b0; mult_en = 1'b0; lda = 1'b0; ldq = 1'b0;
        check("clr_prio busy", 64'(busy), 64'(0));
        count_done(25, "clr_prio no_done");

        run_mult(16'd6, 16'd7, 1'b1, 1'b1, 32'd42, -1, "after_clr");
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
